// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: decodes the incoming instruction word combinationally
// and buffers the decoded result in a 2-entry FIFO. Outputs are zero whenever
// no entry is presented. in_ready depends only on the registered occupancy.
module decode_stage #(
  parameter int PC_W           = 32,
  parameter int ENABLE_M       = 1,
  parameter int HALT_ON_EBREAK = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [31:0]     out_imm,
  output logic [5:0]      out_alucode,
  output logic [1:0]      out_op1_type,
  output logic [1:0]      out_op2_type,
  output logic            out_reg_we,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_halt,
  output logic            out_illegal
);

  // ALU operation codes
  localparam logic [5:0] ALU_NOP  = 6'd0,  ALU_ADD  = 6'd1,  ALU_SUB  = 6'd2,
                         ALU_SLL  = 6'd3,  ALU_SLT  = 6'd4,  ALU_SLTU = 6'd5,
                         ALU_XOR  = 6'd6,  ALU_SRL  = 6'd7,  ALU_SRA  = 6'd8,
                         ALU_OR   = 6'd9,  ALU_AND  = 6'd10, ALU_BEQ  = 6'd11,
                         ALU_BNE  = 6'd12, ALU_BLT  = 6'd13, ALU_BGE  = 6'd14,
                         ALU_BLTU = 6'd15, ALU_BGEU = 6'd16, ALU_JAL  = 6'd17,
                         ALU_JALR = 6'd18, ALU_LB   = 6'd19, ALU_LH   = 6'd20,
                         ALU_LW   = 6'd21, ALU_LBU  = 6'd22, ALU_LHU  = 6'd23,
                         ALU_SB   = 6'd24, ALU_SH   = 6'd25, ALU_SW   = 6'd26,
                         ALU_MUL  = 6'd27, ALU_MULH = 6'd28, ALU_MULHSU = 6'd29,
                         ALU_MULHU = 6'd30, ALU_DIV = 6'd31, ALU_DIVU = 6'd32,
                         ALU_REM  = 6'd33, ALU_REMU = 6'd34;

  // Operand source codes
  localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1,
                         OP_TYPE_IMM  = 2'd2, OP_TYPE_PC  = 2'd3;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011, OPC_OP     = 7'b0110011,
                         OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111,
                         OPC_JAL    = 7'b1101111, OPC_JALR   = 7'b1100111,
                         OPC_BRANCH = 7'b1100011, OPC_LOAD   = 7'b0000011,
                         OPC_STORE  = 7'b0100011, OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [5:0]      alu;
    logic [1:0]      op1;
    logic [1:0]      op2;
    logic            we;
    logic            ld;
    logic            st;
    logic            halt;
    logic            ill;
  } entry_t;

  // Instruction fields
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  f_rd, f_rs1, f_rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc   = in_ir[6:0];
  assign f3    = in_ir[14:12];
  assign f7    = in_ir[31:25];
  assign f_rd  = in_ir[11:7];
  assign f_rs1 = in_ir[19:15];
  assign f_rs2 = in_ir[24:20];
  assign imm_i = {{20{in_ir[31]}}, in_ir[31:20]};
  assign imm_s = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
  assign imm_b = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
  assign imm_u = {in_ir[31:12], 12'h000};
  assign imm_j = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};

  entry_t dec_d;
  logic   bad;

  // Combinational decode of in_ir into a fully populated entry
  always_comb begin
    dec_d    = '0;
    dec_d.pc = in_pc;
    bad      = 1'b0;
    unique case (opc)
      OPC_OPIMM: begin
        dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.imm = imm_i;
        dec_d.op1 = OP_TYPE_REG; dec_d.op2 = OP_TYPE_IMM; dec_d.we = 1'b1;
        case (f3)
          3'b000: dec_d.alu = ALU_ADD;
          3'b010: dec_d.alu = ALU_SLT;
          3'b011: dec_d.alu = ALU_SLTU;
          3'b100: dec_d.alu = ALU_XOR;
          3'b110: dec_d.alu = ALU_OR;
          3'b111: dec_d.alu = ALU_AND;
          3'b001: if (f7 == 7'b0000000) dec_d.alu = ALU_SLL; else bad = 1'b1;
          default: begin
            if      (f7 == 7'b0000000) dec_d.alu = ALU_SRL;
            else if (f7 == 7'b0100000) dec_d.alu = ALU_SRA;
            else                       bad = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.rs2 = f_rs2;
        dec_d.op1 = OP_TYPE_REG; dec_d.op2 = OP_TYPE_REG; dec_d.we = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: dec_d.alu = ALU_ADD;
            3'b001: dec_d.alu = ALU_SLL;
            3'b010: dec_d.alu = ALU_SLT;
            3'b011: dec_d.alu = ALU_SLTU;
            3'b100: dec_d.alu = ALU_XOR;
            3'b101: dec_d.alu = ALU_SRL;
            3'b110: dec_d.alu = ALU_OR;
            default: dec_d.alu = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if      (f3 == 3'b000) dec_d.alu = ALU_SUB;
          else if (f3 == 3'b101) dec_d.alu = ALU_SRA;
          else                   bad = 1'b1;
        end else if (f7 == 7'b0000001 && ENABLE_M != 0) begin
          case (f3)
            3'b000: dec_d.alu = ALU_MUL;
            3'b001: dec_d.alu = ALU_MULH;
            3'b010: dec_d.alu = ALU_MULHSU;
            3'b011: dec_d.alu = ALU_MULHU;
            3'b100: dec_d.alu = ALU_DIV;
            3'b101: dec_d.alu = ALU_DIVU;
            3'b110: dec_d.alu = ALU_REM;
            default: dec_d.alu = ALU_REMU;
          endcase
        end else begin
          bad = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_d.rd = f_rd; dec_d.imm = imm_u; dec_d.alu = ALU_ADD;
        dec_d.op1 = OP_TYPE_NONE; dec_d.op2 = OP_TYPE_IMM; dec_d.we = 1'b1;
      end
      OPC_AUIPC: begin
        dec_d.rd = f_rd; dec_d.imm = imm_u; dec_d.alu = ALU_ADD;
        dec_d.op1 = OP_TYPE_PC; dec_d.op2 = OP_TYPE_IMM; dec_d.we = 1'b1;
      end
      OPC_JAL: begin
        dec_d.rd = f_rd; dec_d.imm = imm_j; dec_d.alu = ALU_JAL;
        dec_d.op1 = OP_TYPE_PC; dec_d.op2 = OP_TYPE_IMM; dec_d.we = 1'b1;
      end
      OPC_JALR: begin
        dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.imm = imm_i; dec_d.alu = ALU_JALR;
        dec_d.op1 = OP_TYPE_REG; dec_d.op2 = OP_TYPE_IMM; dec_d.we = 1'b1;
        if (f3 != 3'b000) bad = 1'b1;
      end
      OPC_BRANCH: begin
        dec_d.rs1 = f_rs1; dec_d.rs2 = f_rs2; dec_d.imm = imm_b;
        dec_d.op1 = OP_TYPE_REG; dec_d.op2 = OP_TYPE_REG;
        case (f3)
          3'b000: dec_d.alu = ALU_BEQ;
          3'b001: dec_d.alu = ALU_BNE;
          3'b100: dec_d.alu = ALU_BLT;
          3'b101: dec_d.alu = ALU_BGE;
          3'b110: dec_d.alu = ALU_BLTU;
          3'b111: dec_d.alu = ALU_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_d.rd = f_rd; dec_d.rs1 = f_rs1; dec_d.imm = imm_i;
        dec_d.op1 = OP_TYPE_REG; dec_d.op2 = OP_TYPE_IMM; dec_d.we = 1'b1; dec_d.ld = 1'b1;
        case (f3)
          3'b000: dec_d.alu = ALU_LB;
          3'b001: dec_d.alu = ALU_LH;
          3'b010: dec_d.alu = ALU_LW;
          3'b100: dec_d.alu = ALU_LBU;
          3'b101: dec_d.alu = ALU_LHU;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_d.rs1 = f_rs1; dec_d.rs2 = f_rs2; dec_d.imm = imm_s;
        dec_d.op1 = OP_TYPE_REG; dec_d.op2 = OP_TYPE_IMM; dec_d.st = 1'b1;
        case (f3)
          3'b000: dec_d.alu = ALU_SB;
          3'b001: dec_d.alu = ALU_SH;
          3'b010: dec_d.alu = ALU_SW;
          default: bad = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        // ECALL/EBREAK carry no operands; anything else (CSR etc.) is rejected
        if      (in_ir == INSN_ECALL)  dec_d.halt = 1'b1;
        else if (in_ir == INSN_EBREAK) dec_d.halt = (HALT_ON_EBREAK != 0);
        else                           bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // Illegal entries carry only the pc and the illegal flag
    if (bad) begin
      dec_d     = '0;
      dec_d.pc  = in_pc;
      dec_d.alu = ALU_NOP;
      dec_d.ill = 1'b1;
    end
    if (dec_d.rd == 5'd0) dec_d.we = 1'b0;
  end

  // 2-entry FIFO state
  entry_t     mem_q [2];
  logic [1:0] cnt_q, cnt_d;
  logic       rd_ptr_q, wr_ptr_q;
  logic       push, pop;
  entry_t     head;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Occupancy next-state
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 2'd1;
    if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  // FIFO storage and pointers; flush overrides push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (flush) begin
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= dec_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Gate the head so nothing stale leaks out when the FIFO is empty
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_pc       = head.pc;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_rd       = head.rd;
  assign out_imm      = head.imm;
  assign out_alucode  = head.alu;
  assign out_op1_type = head.op1;
  assign out_op2_type = head.op2;
  assign out_reg_we   = head.we;
  assign out_is_load  = head.ld;
  assign out_is_store = head.st;
  assign out_is_halt  = head.halt;
  assign out_illegal  = head.ill;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: DUT a uses defaults, DUT b has RV32M
// disabled and EBREAK-as-halt enabled; both see the same stimulus.
module tb_decode_stage;

  localparam logic [31:0] A_NOP = 0, A_ADD = 1, A_SUB = 2, A_BEQ = 11, A_JAL = 17,
                          A_LW = 21, A_SW = 26, A_MUL = 27;
  localparam logic [31:0] T_NONE = 0, T_REG = 1, T_IMM = 2, T_PC = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ir = '0, in_pc = '0;

  logic        a_in_ready, a_out_valid, a_we, a_ld, a_st, a_halt, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [5:0]  a_alu;
  logic [1:0]  a_op1, a_op2;
  logic        b_in_ready, b_out_valid, b_we, b_ld, b_st, b_halt, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [5:0]  b_alu;
  logic [1:0]  b_op1, b_op2;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage #(.PC_W(32), .ENABLE_M(1), .HALT_ON_EBREAK(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_rd(a_rd), .out_imm(a_imm), .out_alucode(a_alu), .out_op1_type(a_op1),
    .out_op2_type(a_op2), .out_reg_we(a_we), .out_is_load(a_ld),
    .out_is_store(a_st), .out_is_halt(a_halt), .out_illegal(a_ill));

  decode_stage #(.PC_W(32), .ENABLE_M(0), .HALT_ON_EBREAK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_rd(b_rd), .out_imm(b_imm), .out_alucode(b_alu), .out_op1_type(b_op1),
    .out_op2_type(b_op2), .out_reg_we(b_we), .out_is_load(b_ld),
    .out_is_store(b_st), .out_is_halt(b_halt), .out_illegal(b_ill));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full decoded-entry check on DUT a (sel=0) or DUT b (sel=1)
  task automatic chk_dec(input string tag, input bit sel,
                         input logic [31:0] pc, input logic [31:0] rd,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] alu,
                         input logic [31:0] op1, input logic [31:0] op2,
                         input logic [4:0] flg);  // {we,ld,st,halt,ill}
    chk({tag, ".valid"}, sel ? b_out_valid : a_out_valid, 1);
    chk({tag, ".pc"},    sel ? b_pc  : a_pc,  pc);
    chk({tag, ".rd"},    sel ? b_rd  : a_rd,  rd);
    chk({tag, ".rs1"},   sel ? b_rs1 : a_rs1, rs1);
    chk({tag, ".rs2"},   sel ? b_rs2 : a_rs2, rs2);
    chk({tag, ".imm"},   sel ? b_imm : a_imm, imm);
    chk({tag, ".alu"},   sel ? b_alu : a_alu, alu);
    chk({tag, ".op1"},   sel ? b_op1 : a_op1, op1);
    chk({tag, ".op2"},   sel ? b_op2 : a_op2, op2);
    chk({tag, ".flags"}, sel ? {b_we, b_ld, b_st, b_halt, b_ill}
                             : {a_we, a_ld, a_st, a_halt, a_ill}, {27'd0, flg});
  endtask

  task automatic push(input logic [31:0] ir, input logic [31:0] pc);
    in_valid = 1'b1; in_ir = ir; in_pc = pc;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst.valid", a_out_valid, 0);
    chk("rst.imm", a_imm, 0);
    chk("rst.b_ready", b_in_ready, 1);
    #9 rst_n = 1'b1;
    step();
    chk("rel.ready", a_in_ready, 1);
    chk("rel.valid", a_out_valid, 0);

    // Decode vectors, streaming one per cycle
    out_ready = 1'b1;
    push(32'hFFF00093, 32'h100);  // addi x1,x0,-1
    chk_dec("addi", 0, 32'h100, 1, 0, 0, 32'hFFFFFFFF, A_ADD, T_REG, T_IMM, 5'b10000);
    push(32'hFE208EE3, 32'h104);  // beq x1,x2,-4
    chk_dec("beq", 0, 32'h104, 0, 1, 2, 32'hFFFFFFFC, A_BEQ, T_REG, T_REG, 5'b00000);
    push(32'h022081B3, 32'h108);  // mul x3,x1,x2
    chk_dec("mul", 0, 32'h108, 3, 1, 2, 0, A_MUL, T_REG, T_REG, 5'b10000);
    chk_dec("mul_noM", 1, 32'h108, 0, 0, 0, 0, A_NOP, T_NONE, T_NONE, 5'b00001);
    push(32'h402081B3, 32'h10C);  // sub x3,x1,x2
    chk_dec("sub", 0, 32'h10C, 3, 1, 2, 0, A_SUB, T_REG, T_REG, 5'b10000);
    push(32'h123452B7, 32'h110);  // lui x5,0x12345
    chk_dec("lui", 0, 32'h110, 5, 0, 0, 32'h12345000, A_ADD, T_NONE, T_IMM, 5'b10000);
    push(32'h0020A423, 32'h114);  // sw x2,8(x1)
    chk_dec("sw", 0, 32'h114, 0, 1, 2, 8, A_SW, T_REG, T_IMM, 5'b00100);
    push(32'hFFC1A203, 32'h118);  // lw x4,-4(x3)
    chk_dec("lw", 0, 32'h118, 4, 3, 0, 32'hFFFFFFFC, A_LW, T_REG, T_IMM, 5'b11000);
    push(32'h801FF0EF, 32'h11C);  // jal x1,-2048
    chk_dec("jal", 0, 32'h11C, 1, 0, 0, 32'hFFFFF800, A_JAL, T_PC, T_IMM, 5'b10000);
    push(32'h00000013, 32'h120);  // addi x0,x0,0: write to x0 suppressed
    chk_dec("nop", 0, 32'h120, 0, 0, 0, 0, A_ADD, T_REG, T_IMM, 5'b00000);
    push(32'h00000073, 32'h124);  // ecall
    chk_dec("ecall", 0, 32'h124, 0, 0, 0, 0, A_NOP, T_NONE, T_NONE, 5'b00010);
    push(32'h00100073, 32'h128);  // ebreak
    chk_dec("ebreak", 0, 32'h128, 0, 0, 0, 0, A_NOP, T_NONE, T_NONE, 5'b00000);
    chk_dec("ebreak_h", 1, 32'h128, 0, 0, 0, 0, A_NOP, T_NONE, T_NONE, 5'b00010);
    push(32'hFFFFFFFF, 32'h12C);  // unknown opcode
    chk_dec("unk", 0, 32'h12C, 0, 0, 0, 0, A_NOP, T_NONE, T_NONE, 5'b00001);
    step();
    chk("drain.valid", a_out_valid, 0);
    chk("drain.imm", a_imm, 0);

    // Backpressure: A,B fill the FIFO, C waits, then all drain in order
    out_ready = 1'b0;
    push(32'hFFF00093, 32'h200);
    chk("bp.A.pc", a_pc, 32'h200);
    chk("bp.ready1", a_in_ready, 1);
    push(32'h0020A423, 32'h204);
    chk("bp.ready2", a_in_ready, 0);
    in_valid = 1'b1; in_ir = 32'h123452B7; in_pc = 32'h208;
    step();
    chk("bp.hold.ready", a_in_ready, 0);
    chk("bp.hold.pc", a_pc, 32'h200);
    chk("bp.hold.imm", a_imm, 32'hFFFFFFFF);
    out_ready = 1'b1;
    step();
    chk("bp.B.pc", a_pc, 32'h204);
    chk("bp.B.imm", a_imm, 8);
    chk("bp.B.ready", a_in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("bp.C.pc", a_pc, 32'h208);
    chk("bp.C.imm", a_imm, 32'h12345000);
    step();
    chk("bp.end.valid", a_out_valid, 0);

    // Flush at occupancy 2 with a same-cycle push
    out_ready = 1'b0;
    push(32'hFFF00093, 32'h300);
    push(32'hFE208EE3, 32'h304);
    chk("fl.full", a_in_ready, 0);
    flush = 1'b1; in_valid = 1'b1; in_ir = 32'h022081B3; in_pc = 32'h3FC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.valid", a_out_valid, 0);
    chk("fl.ready", a_in_ready, 1);
    chk("fl.pc", a_pc, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl.stay_empty", a_out_valid, 0);
    end
    push(32'hFFF00093, 32'h310);
    chk("fl.after.pc", a_pc, 32'h310);
    step();

    // Async reset mid-stream at occupancy 1
    out_ready = 1'b0;
    push(32'hFFC1A203, 32'h400);
    chk("ar.pre.valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid", a_out_valid, 0);
    chk("ar.pc", a_pc, 0);
    chk("ar.imm", a_imm, 0);
    chk("ar.rd", a_rd, 0);
    chk("ar.alu", a_alu, 0);
    chk("ar.flags", {a_we, a_ld}, 0);
    #3 rst_n = 1'b1;
    step();
    chk("ar.rel.ready", a_in_ready, 1);
    chk("ar.rel.valid", a_out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
